// File: rtl/risc_seq_ctrl_if.sv
// Memory-side handshake bundle for the RISC sequencer: instruction fetch port
// and data-memory access port. The sequencer is the master; memories are slaves.
interface risc_seq_ctrl_if #(
    parameter int PC_W    = 4,
    parameter int INSTR_W = 8
);
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;
    logic               dmem_req;
    logic               dmem_we;
    logic               dmem_ack;

    modport master (
        output imem_req, imem_addr, dmem_req, dmem_we,
        input  imem_ack, imem_rdata, dmem_ack
    );

    modport slave (
        input  imem_req, imem_addr, dmem_req, dmem_we,
        output imem_ack, imem_rdata, dmem_ack
    );
endinterface

// File: rtl/risc_seq_ctrl.sv
// Multi-cycle control sequencer for the 4-bit RISC datapath: owns PC and IR,
// walks FETCH/DECODE/EXEC/MEM/WB and drives regfile, ALU and memory controls.
module risc_seq_ctrl #(
    parameter int PC_W    = 4,
    parameter int INSTR_W = 8,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    risc_seq_ctrl_if.master    bus,
    input  logic               zero_flag,
    output logic [1:0]         rf_ra,
    output logic [1:0]         rf_rb,
    output logic               rf_we,
    output logic [1:0]         rf_wsel,
    output logic [1:0]         wb_src,
    output logic [1:0]         alu_op,
    output logic               flag_we,
    output logic [PC_W-1:0]    pc,
    output logic [INSTR_W-1:0] ir,
    output logic               halted,
    output logic               illegal,
    output logic [CNT_W-1:0]   retired
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t             state_reg,   state_next;
    logic [PC_W-1:0]    pc_reg,      pc_next;
    logic [INSTR_W-1:0] ir_reg,      ir_next;
    logic [CNT_W-1:0]   retired_reg, retired_next;
    logic               illegal_reg, illegal_next;
    logic               pend_reg,    pend_next;

    logic               retire;
    logic               imem_req_c;
    logic               dmem_req_c;
    logic               rf_we_c;
    logic               flag_we_c;

    // Instruction fields; decode is purely a function of IR, so the derived
    // controls stay stable for the whole instruction once IR is loaded.
    logic [3:0]  opcode;
    logic [1:0]  rd;
    logic [1:0]  rs;
    logic [3:0]  imm;
    logic [15:0] op_hot;

    assign opcode = ir_reg[INSTR_W-1 -: 4];
    assign rd     = ir_reg[3:2];
    assign rs     = ir_reg[1:0];
    assign imm    = ir_reg[3:0];

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_op_dec
            assign op_hot[gi] = (opcode == 4'(gi));
        end
    endgenerate

    logic is_alu, is_ldi, is_ld, is_st, is_flow, is_halt, is_bad;

    assign is_alu  = op_hot[1] | op_hot[2] | op_hot[3] | op_hot[4];
    assign is_ldi  = op_hot[5];
    assign is_ld   = op_hot[6];
    assign is_st   = op_hot[7];
    assign is_flow = op_hot[0] | op_hot[8] | op_hot[9];
    assign is_halt = op_hot[15];
    assign is_bad  = |op_hot[14:10];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_FETCH;
            pc_reg      <= '0;
            ir_reg      <= '0;
            retired_reg <= '0;
            illegal_reg <= 1'b0;
            pend_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            ir_reg      <= ir_next;
            retired_reg <= retired_next;
            illegal_reg <= illegal_next;
            pend_reg    <= pend_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        ir_next      = ir_reg;
        illegal_next = illegal_reg;
        pend_next    = pend_reg;
        retire       = 1'b0;
        imem_req_c   = 1'b0;
        dmem_req_c   = 1'b0;
        rf_we_c      = 1'b0;
        flag_we_c    = 1'b0;

        case (state_reg)
            S_FETCH: begin
                // A request already on the bus is held until acknowledged,
                // even if run is withdrawn in the meantime.
                imem_req_c = run | pend_reg;
                if (imem_req_c && bus.imem_ack) begin
                    ir_next    = bus.imem_rdata;
                    pc_next    = pc_reg + PC_W'(1);
                    pend_next  = 1'b0;
                    state_next = S_DECODE;
                end else begin
                    pend_next  = imem_req_c;
                end
            end
            S_DECODE: begin
                if (is_bad) begin
                    illegal_next = 1'b1;
                    state_next   = S_HALT;
                end else if (is_halt) begin
                    retire     = 1'b1;
                    state_next = S_HALT;
                end else begin
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_alu || is_ldi) begin
                    state_next = S_WB;
                end else if (is_ld || is_st) begin
                    state_next = S_MEM;
                end else if (is_flow) begin
                    if (op_hot[8] || (op_hot[9] && zero_flag))
                        pc_next = PC_W'(imm);
                    retire     = 1'b1;
                    state_next = S_FETCH;
                end else begin
                    state_next = S_FETCH;
                end
            end
            S_MEM: begin
                dmem_req_c = 1'b1;
                if (bus.dmem_ack) begin
                    if (is_st) begin
                        retire     = 1'b1;
                        state_next = S_FETCH;
                    end else begin
                        state_next = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_we_c    = 1'b1;
                flag_we_c  = is_alu;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_HALT: begin
                state_next = S_HALT;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase

        if (retire && (retired_reg != {CNT_W{1'b1}}))
            retired_next = retired_reg + CNT_W'(1);
        else
            retired_next = retired_reg;
    end

    always_comb begin
        alu_op = 2'd0;
        if (op_hot[2]) alu_op = 2'd1;
        if (op_hot[3]) alu_op = 2'd2;
        if (op_hot[4]) alu_op = 2'd3;
    end

    always_comb begin
        wb_src = 2'd0;
        if (is_ldi) wb_src = 2'd1;
        if (is_ld)  wb_src = 2'd2;
    end

    assign rf_wsel = is_ldi ? 2'd0 : rd;
    assign rf_ra   = rd;
    assign rf_rb   = rs;
    assign rf_we   = rf_we_c;
    assign flag_we = flag_we_c;
    assign pc      = pc_reg;
    assign ir      = ir_reg;
    assign halted  = (state_reg == S_HALT);
    assign illegal = illegal_reg;
    assign retired = retired_reg;

    assign bus.imem_req  = imem_req_c;
    assign bus.imem_addr = pc_reg;
    assign bus.dmem_req  = dmem_req_c;
    assign bus.dmem_we   = dmem_req_c & is_st;

endmodule

// File: tb/tb_risc_seq_ctrl.sv
// Directed bench for risc_seq_ctrl: drives inputs on the falling edge and
// checks outputs there, half a period away from the rising edge.
module tb_risc_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run;
    logic       zero_flag;
    logic [1:0] rf_ra, rf_rb, rf_wsel, wb_src, alu_op;
    logic       rf_we, flag_we, halted, illegal;
    logic [3:0] pc;
    logic [7:0] ir;
    logic [7:0] retired;

    int errors = 0;
    int checks = 0;

    risc_seq_ctrl_if #(.PC_W(4), .INSTR_W(8)) bus ();

    risc_seq_ctrl #(.PC_W(4), .INSTR_W(8), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .bus       (bus),
        .zero_flag (zero_flag),
        .rf_ra     (rf_ra),
        .rf_rb     (rf_rb),
        .rf_we     (rf_we),
        .rf_wsel   (rf_wsel),
        .wb_src    (wb_src),
        .alu_op    (alu_op),
        .flag_we   (flag_we),
        .pc        (pc),
        .ir        (ir),
        .halted    (halted),
        .illegal   (illegal),
        .retired   (retired)
    );

    always #5 clk = ~clk;

    // Waits (bounded) for a fetch request, answers it with zero wait states,
    // and returns on the falling edge of the DECODE cycle.
    task automatic fetch(input logic [7:0] instr);
        int n = 0;
        while (bus.imem_req !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.imem_req !== 1'b1) begin
            errors++;
            $display("FAIL fetch_req: imem_req=%b required 1", bus.imem_req);
        end
        $display("fetch addr=%0d instr=%02h", bus.imem_addr, instr);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = instr;
        @(negedge clk);
        bus.imem_ack   = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; run = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (pc !== 4'd0 || bus.imem_req !== 1'b0 || halted !== 1'b0 || retired !== 8'd0) begin
            errors++;
            $display("FAIL reset_state: pc=%0d req=%b halted=%b retired=%0d required 0 0 0 0",
                     pc, bus.imem_req, halted, retired);
        end
        rst_n = 1'b1; run = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 4'd0) begin
            errors++;
            $display("FAIL reset_release: req=%b addr=%0d required 1 0", bus.imem_req, bus.imem_addr);
        end
    endtask

    task automatic test_add;
        fetch(8'h16);
        checks++;
        if (rf_we !== 1'b0 || rf_ra !== 2'd1 || rf_rb !== 2'd2 || alu_op !== 2'd0) begin
            errors++;
            $display("FAIL add_decode: we=%b ra=%0d rb=%0d op=%0d required 0 1 2 0", rf_we, rf_ra, rf_rb, alu_op);
        end
        @(negedge clk);
        checks++;
        if (rf_we !== 1'b0) begin
            errors++;
            $display("FAIL add_exec_we: rf_we=%b required 0", rf_we);
        end
        @(negedge clk);
        checks++;
        if (rf_we !== 1'b1 || rf_wsel !== 2'd1 || alu_op !== 2'd0 || flag_we !== 1'b1 || wb_src !== 2'd0) begin
            errors++;
            $display("FAIL add_wb: we=%b wsel=%0d op=%0d fwe=%b src=%0d required 1 1 0 1 0",
                     rf_we, rf_wsel, alu_op, flag_we, wb_src);
        end
        @(negedge clk);
        checks++;
        if (rf_we !== 1'b0 || pc !== 4'd1 || retired !== 8'd1 || bus.imem_addr !== 4'd1) begin
            errors++;
            $display("FAIL add_done: we=%b pc=%0d retired=%0d addr=%0d required 0 1 1 1",
                     rf_we, pc, retired, bus.imem_addr);
        end
    endtask

    task automatic test_ld_wait;
        int high_cnt = 0;
        fetch(8'h61);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            if (bus.dmem_req === 1'b1 && bus.dmem_we === 1'b0) high_cnt++;
            if (i == 3) bus.dmem_ack = 1'b1;
            @(negedge clk);
        end
        bus.dmem_ack = 1'b0;
        checks++;
        if (high_cnt != 4) begin
            errors++;
            $display("FAIL ld_req_cycles: got %0d required 4", high_cnt);
        end
        checks++;
        if (rf_we !== 1'b1 || wb_src !== 2'd2 || rf_wsel !== 2'd0 || flag_we !== 1'b0 || bus.dmem_req !== 1'b0) begin
            errors++;
            $display("FAIL ld_wb: we=%b src=%0d wsel=%0d fwe=%b dreq=%b required 1 2 0 0 0",
                     rf_we, wb_src, rf_wsel, flag_we, bus.dmem_req);
        end
        @(negedge clk);
        checks++;
        if (bus.imem_req !== 1'b1 || pc !== 4'd2 || retired !== 8'd2) begin
            errors++;
            $display("FAIL ld_done: req=%b pc=%0d retired=%0d required 1 2 2", bus.imem_req, pc, retired);
        end
    endtask

    task automatic test_st;
        fetch(8'h74);
        repeat (2) @(negedge clk);
        checks++;
        if (bus.dmem_req !== 1'b1 || bus.dmem_we !== 1'b1) begin
            errors++;
            $display("FAIL st_mem: dreq=%b we=%b required 1 1", bus.dmem_req, bus.dmem_we);
        end
        bus.dmem_ack = 1'b1;
        @(negedge clk);
        bus.dmem_ack = 1'b0;
        checks++;
        if (bus.dmem_req !== 1'b0 || rf_we !== 1'b0 || bus.imem_req !== 1'b1 || retired !== 8'd3 || pc !== 4'd3) begin
            errors++;
            $display("FAIL st_done: dreq=%b we=%b ireq=%b retired=%0d pc=%0d required 0 0 1 3 3",
                     bus.dmem_req, rf_we, bus.imem_req, retired, pc);
        end
    endtask

    task automatic test_jumps;
        zero_flag = 1'b1;
        fetch(8'h9C);
        repeat (2) @(negedge clk);
        checks++;
        if (bus.imem_addr !== 4'd12 || retired !== 8'd4) begin
            errors++;
            $display("FAIL jz_taken: addr=%0d retired=%0d required 12 4", bus.imem_addr, retired);
        end
        zero_flag = 1'b0;
        fetch(8'h9C);
        repeat (2) @(negedge clk);
        checks++;
        if (bus.imem_addr !== 4'd13 || retired !== 8'd5) begin
            errors++;
            $display("FAIL jz_not_taken: addr=%0d retired=%0d required 13 5", bus.imem_addr, retired);
        end
        fetch(8'h8F);
        repeat (2) @(negedge clk);
        checks++;
        if (bus.imem_addr !== 4'd15 || retired !== 8'd6) begin
            errors++;
            $display("FAIL jmp: addr=%0d retired=%0d required 15 6", bus.imem_addr, retired);
        end
        fetch(8'h00);
        repeat (2) @(negedge clk);
        checks++;
        if (bus.imem_addr !== 4'd0 || retired !== 8'd7) begin
            errors++;
            $display("FAIL pc_wrap: addr=%0d retired=%0d required 0 7", bus.imem_addr, retired);
        end
    endtask

    task automatic test_ldi_and_alu;
        logic [7:0] instr_tab [4] = '{8'h5A, 8'h2B, 8'h3C, 8'h4D};
        logic [1:0] op_tab    [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
        logic [1:0] wsel_tab  [4] = '{2'd0, 2'd2, 2'd3, 2'd3};
        logic [1:0] src_tab   [4] = '{2'd1, 2'd0, 2'd0, 2'd0};
        logic       fwe_tab   [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            fetch(instr_tab[i]);
            repeat (2) @(negedge clk);
            checks++;
            if (rf_we !== 1'b1 || alu_op !== op_tab[i] || rf_wsel !== wsel_tab[i] ||
                wb_src !== src_tab[i] || flag_we !== fwe_tab[i]) begin
                errors++;
                $display("FAIL wb_%02h: we=%b op=%0d wsel=%0d src=%0d fwe=%b required 1 %0d %0d %0d %b",
                         instr_tab[i], rf_we, alu_op, rf_wsel, wb_src, flag_we,
                         op_tab[i], wsel_tab[i], src_tab[i], fwe_tab[i]);
            end
            @(negedge clk);
        end
        checks++;
        if (retired !== 8'd11 || pc !== 4'd4) begin
            errors++;
            $display("FAIL alu_seq_done: retired=%0d pc=%0d required 11 4", retired, pc);
        end
    endtask

    task automatic test_run_hold;
        @(negedge clk);
        run = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.imem_req !== 1'b1) begin
            errors++;
            $display("FAIL req_hold: imem_req=%b required 1", bus.imem_req);
        end
        fetch(8'h00);
        repeat (2) @(negedge clk);
        checks++;
        if (bus.imem_req !== 1'b0 || retired !== 8'd12) begin
            errors++;
            $display("FAIL run_low_idle: imem_req=%b retired=%0d required 0 12", bus.imem_req, retired);
        end
        run = 1'b1;
    endtask

    task automatic test_illegal;
        int req_seen = 0;
        fetch(8'hB0);
        @(negedge clk);
        checks++;
        if (halted !== 1'b1 || illegal !== 1'b1 || retired !== 8'd12 || pc !== 4'd6) begin
            errors++;
            $display("FAIL illegal_halt: halted=%b illegal=%b retired=%0d pc=%0d required 1 1 12 6",
                     halted, illegal, retired, pc);
        end
        repeat (20) begin
            @(negedge clk);
            if (bus.imem_req !== 1'b0 || bus.dmem_req !== 1'b0 || rf_we !== 1'b0) req_seen++;
        end
        checks++;
        if (req_seen != 0) begin
            errors++;
            $display("FAIL halt_quiet: active cycles=%0d required 0", req_seen);
        end
    endtask

    task automatic test_reset_mid_mem;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (halted !== 1'b0 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL reset_clears_halt: halted=%b illegal=%b required 0 0", halted, illegal);
        end
        fetch(8'h61);
        repeat (2) @(negedge clk);
        checks++;
        if (bus.dmem_req !== 1'b1) begin
            errors++;
            $display("FAIL mid_mem_req: dmem_req=%b required 1", bus.dmem_req);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.dmem_req !== 1'b0 || pc !== 4'd0 || ir !== 8'h00) begin
            errors++;
            $display("FAIL async_reset: dmem_req=%b pc=%0d ir=%02h required 0 0 00", bus.dmem_req, pc, ir);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 4'd0 || retired !== 8'd0) begin
            errors++;
            $display("FAIL restart: req=%b addr=%0d retired=%0d required 1 0 0",
                     bus.imem_req, bus.imem_addr, retired);
        end
    endtask

    task automatic test_halt_op;
        fetch(8'hF0);
        @(negedge clk);
        checks++;
        if (halted !== 1'b1 || illegal !== 1'b0 || retired !== 8'd1 || bus.imem_req !== 1'b0) begin
            errors++;
            $display("FAIL halt_op: halted=%b illegal=%b retired=%0d req=%b required 1 0 1 0",
                     halted, illegal, retired, bus.imem_req);
        end
    endtask

    task automatic test_saturate;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 260; i++) begin
            fetch(8'h00);
            @(negedge clk);
        end
        @(negedge clk);
        checks++;
        if (retired !== 8'd255 || pc !== 4'd4) begin
            errors++;
            $display("FAIL retired_saturate: retired=%0d pc=%0d required 255 4", retired, pc);
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        run            = 1'b0;
        zero_flag      = 1'b0;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 8'h00;
        bus.dmem_ack   = 1'b0;
        test_reset();
        test_add();
        test_ld_wait();
        test_st();
        test_jumps();
        test_ldi_and_alu();
        test_run_hold();
        test_illegal();
        test_reset_mid_mem();
        test_halt_op();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
